// File: rtl/cpu_io_initiator.sv
// cpu_io_initiator: on-chip requester of Z80-style I/O cycles toward the port
// decoder. Takes one command at a time, requests the bus, runs T1/T2/TW/T3
// paced by clkcpu_ck and returns a one-clk28 response pulse.
// Handshake: a command transfers on the clk28 edge where cmd_valid && cmd_ready;
// cmd_ready is high only in IDLE and the cmd_* inputs are ignored elsewhere.
// rsp_valid is a single-cycle pulse with no backpressure; rsp_rdata/rsp_err
// hold until the next response.
module cpu_io_initiator #(
    parameter int WAIT_STATES   = 1,
    parameter int GRANT_TIMEOUT = 255
) (
    input  logic        clk28,
    input  logic        rst_n,
    input  logic        clkcpu_ck,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic [15:0] a_out,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic        ioreq,
    output logic        rd,
    output logic        wr,
    input  logic [7:0]  d_in,
    input  logic        d_in_active
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_T1, S_T2, S_TW, S_T3} state_e;

    localparam logic [3:0] WS_L = 4'(WAIT_STATES);
    localparam logic [8:0] GT_L = 9'(GRANT_TIMEOUT);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [2:0]  wait_q, wait_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        bus_req_q, bus_req_d;
    logic [15:0] a_out_q, a_out_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        d_oe_q, d_oe_d;
    logic        ioreq_q, ioreq_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;

    logic accept;
    logic timeout_hit;
    logic wait_last;

    assign accept      = cmd_valid && cmd_ready_q;
    // The strobe that would bring the grant-wait count to GRANT_TIMEOUT aborts.
    assign timeout_hit = ({1'b0, tmo_q} + 9'd1) == GT_L;
    // The TW strobe that completes WAIT_STATES wait periods moves on to T3.
    assign wait_last   = ({1'b0, wait_q} + 4'd1) == WS_L;

    // State register; reset aborts any cycle in flight without a response.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: leaving IDLE is clk28-paced, everything else waits for a strobe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_REQ;
            S_REQ: begin
                if (clkcpu_ck) begin
                    if (bus_grant)        state_d = S_T1;
                    else if (timeout_hit) state_d = S_IDLE;
                end
            end
            S_T1: if (clkcpu_ck) state_d = S_T2;
            S_T2: if (clkcpu_ck) state_d = (WAIT_STATES > 0) ? S_TW : S_T3;
            S_TW: if (clkcpu_ck && wait_last) state_d = S_T3;
            S_T3: if (clkcpu_ck) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; every output is registered from these.
    always_comb begin
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tmo_d       = tmo_q;
        wait_d      = wait_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        bus_req_d   = bus_req_q;
        a_out_d     = a_out_q;
        d_out_d     = d_out_q;
        d_oe_d      = d_oe_q;
        ioreq_d     = ioreq_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d        = cmd_we;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    tmo_d       = 8'd0;
                    bus_req_d   = 1'b1;
                    cmd_ready_d = 1'b0;
                end
            end
            S_REQ: begin
                if (clkcpu_ck) begin
                    if (bus_grant) begin
                        a_out_d = addr_q;
                        d_out_d = wdata_q;
                        d_oe_d  = we_q;
                    end else if (timeout_hit) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 8'hFF;
                        bus_req_d   = 1'b0;
                        cmd_ready_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
            end
            S_T1: begin
                if (clkcpu_ck) begin
                    ioreq_d = 1'b1;
                    rd_d    = ~we_q;
                    wr_d    = we_q;
                end
            end
            S_T2: if (clkcpu_ck) wait_d = 3'd0;
            S_TW: if (clkcpu_ck && !wait_last) wait_d = wait_q + 3'd1;
            S_T3: begin
                if (clkcpu_ck) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = (we_q || !d_in_active) ? 8'hFF : d_in;
                    ioreq_d     = 1'b0;
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                    d_oe_d      = 1'b0;
                    bus_req_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            tmo_q       <= 8'd0;
            wait_q      <= 3'd0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'hFF;
            rsp_err_q   <= 1'b0;
            bus_req_q   <= 1'b0;
            a_out_q     <= 16'h0000;
            d_out_q     <= 8'h00;
            d_oe_q      <= 1'b0;
            ioreq_q     <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
        end else begin
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tmo_q       <= tmo_d;
            wait_q      <= wait_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            bus_req_q   <= bus_req_d;
            a_out_q     <= a_out_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
            ioreq_q     <= ioreq_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign bus_req   = bus_req_q;
    assign a_out     = a_out_q;
    assign d_out     = d_out_q;
    assign d_oe      = d_oe_q;
    assign ioreq     = ioreq_q;
    assign rd        = rd_q;
    assign wr        = wr_q;

endmodule

// File: tb/tb_cpu_io_initiator.sv
// Directed bench for cpu_io_initiator. Instance 0 uses WAIT_STATES=1 and
// instance 1 WAIT_STATES=0; both use GRANT_TIMEOUT=4. Inputs change on the
// falling edge and outputs are sampled there too.
module tb_cpu_io_initiator;

    logic        clk28 = 1'b0;
    logic        rst_n = 1'b1;
    logic        clkcpu_ck = 1'b0;
    logic        cmd_valid [2];
    logic        cmd_we = 1'b0;
    logic [15:0] cmd_addr = 16'h0000;
    logic [7:0]  cmd_wdata = 8'h00;
    logic        bus_grant = 1'b1;
    logic [7:0]  d_in = 8'h00;
    logic        d_in_active = 1'b0;

    logic        cmd_ready [2];
    logic        rsp_valid [2];
    logic [7:0]  rsp_rdata [2];
    logic        rsp_err   [2];
    logic        bus_req   [2];
    logic [15:0] a_out     [2];
    logic [7:0]  d_out     [2];
    logic        d_oe      [2];
    logic        ioreq     [2];
    logic        rd        [2];
    logic        wr        [2];

    int n_checks = 0;
    int n_errors = 0;

    // results captured by run_cmd
    logic        r_done, r_ready0, r_rd, r_wr, r_io, r_oe, r_err;
    logic [15:0] r_a;
    logic [7:0]  r_d, r_rdata;
    int          r_strb, r_strb_io, r_strb_req;

    cpu_io_initiator #(.WAIT_STATES(1), .GRANT_TIMEOUT(4)) dut (
        .clk28(clk28), .rst_n(rst_n), .clkcpu_ck(clkcpu_ck),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .bus_req(bus_req[0]), .bus_grant(bus_grant),
        .a_out(a_out[0]), .d_out(d_out[0]), .d_oe(d_oe[0]),
        .ioreq(ioreq[0]), .rd(rd[0]), .wr(wr[0]),
        .d_in(d_in), .d_in_active(d_in_active)
    );

    cpu_io_initiator #(.WAIT_STATES(0), .GRANT_TIMEOUT(4)) dut0 (
        .clk28(clk28), .rst_n(rst_n), .clkcpu_ck(clkcpu_ck),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .bus_req(bus_req[1]), .bus_grant(bus_grant),
        .a_out(a_out[1]), .d_out(d_out[1]), .d_oe(d_oe[1]),
        .ioreq(ioreq[1]), .rd(rd[1]), .wr(wr[1]),
        .d_in(d_in), .d_in_active(d_in_active)
    );

    // clock and CPU strobe: one clk28-wide pulse every 8 clk28 cycles
    always #5 clk28 = ~clk28;

    logic [2:0] div = 3'd0;
    always @(posedge clk28) begin
        #1;
        div = div + 3'd1;
        clkcpu_ck = (div == 3'd7);
    end

    // Issue one command on instance s and follow it until its response.
    // gmode 0: grant high, 1: grant low, 2: grant high only for strobes 3..4.
    // At each falling edge clkcpu_ck is the strobe the next rising edge sees.
    task automatic run_cmd(input int s, input logic we, input logic [15:0] addr,
                           input logic [7:0] wd, input logic act,
                           input logic [7:0] din, input int gmode);
        r_done = 0; r_rd = 0; r_wr = 0; r_io = 0; r_oe = 0; r_err = 0;
        r_a = 16'h0; r_d = 8'h0; r_rdata = 8'h0;
        r_strb = 0; r_strb_io = 0; r_strb_req = 0;
        r_ready0 = cmd_ready[s];
        cmd_we = we; cmd_addr = addr; cmd_wdata = wd;
        bus_grant = (gmode == 0);
        cmd_valid[s] = 1'b1;
        @(negedge clk28);
        cmd_valid[s] = 1'b0;
        cmd_addr = 16'hDEAD; cmd_wdata = 8'hEE; cmd_we = ~we;
        for (int c = 0; c < 400 && !r_done; c++) begin
            if (ioreq[s]) begin
                r_io = 1; r_a = a_out[s]; r_d = d_out[s]; r_oe = d_oe[s];
            end
            if (rd[s]) r_rd = 1;
            if (wr[s]) r_wr = 1;
            if (rsp_valid[s]) begin
                r_done = 1; r_rdata = rsp_rdata[s]; r_err = rsp_err[s];
            end else begin
                if (clkcpu_ck) begin
                    r_strb++;
                    if (ioreq[s])   r_strb_io++;
                    if (bus_req[s]) r_strb_req++;
                end
                if (gmode == 2) bus_grant = (r_strb >= 3 && r_strb <= 4);
                d_in        = ioreq[s] ? din : 8'h5A;
                d_in_active = ioreq[s] & act;
                @(negedge clk28);
            end
        end
        d_in_active = 1'b0;
        bus_grant = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk28);
        n_checks++; if (cmd_ready[0] !== 1'b1) begin n_errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready[0]); end
        n_checks++; if (rsp_rdata[0] !== 8'hFF) begin n_errors++; $display("FAIL reset_rsp_rdata got %h exp FF", rsp_rdata[0]); end
        n_checks++; if ({rsp_valid[0], rsp_err[0], bus_req[0], d_oe[0], ioreq[0], rd[0], wr[0]} !== 7'b0)
            begin n_errors++; $display("FAIL reset_ctrl got %b exp 0000000", {rsp_valid[0], rsp_err[0], bus_req[0], d_oe[0], ioreq[0], rd[0], wr[0]}); end
        n_checks++; if ({a_out[0], d_out[0]} !== 24'h0) begin n_errors++; $display("FAIL reset_bus got %h exp 000000", {a_out[0], d_out[0]}); end
        n_checks++; if (cmd_ready[1] !== 1'b1) begin n_errors++; $display("FAIL reset_cmd_ready_ws0 got %b exp 1", cmd_ready[1]); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk28);
    endtask

    task automatic test_out_write();
        run_cmd(0, 1'b1, 16'h7FFD, 8'h15, 1'b0, 8'h00, 0);
        n_checks++; if (r_done !== 1'b1) begin n_errors++; $display("FAIL out_done got %b exp 1", r_done); end
        n_checks++; if (r_strb != 5) begin n_errors++; $display("FAIL out_latency_strobes got %0d exp 5", r_strb); end
        n_checks++; if (r_strb_io != 3) begin n_errors++; $display("FAIL out_ioreq_strobes got %0d exp 3", r_strb_io); end
        n_checks++; if (r_strb_req != 5) begin n_errors++; $display("FAIL out_busreq_strobes got %0d exp 5", r_strb_req); end
        n_checks++; if ({r_a, r_d, r_oe} !== {16'h7FFD, 8'h15, 1'b1}) begin n_errors++; $display("FAIL out_bus got a=%h d=%h oe=%b exp 7FFD 15 1", r_a, r_d, r_oe); end
        n_checks++; if ({r_wr, r_rd} !== 2'b10) begin n_errors++; $display("FAIL out_strobes got wr=%b rd=%b exp 1 0", r_wr, r_rd); end
        n_checks++; if ({r_rdata, r_err} !== {8'hFF, 1'b0}) begin n_errors++; $display("FAIL out_rsp got %h/%b exp FF/0", r_rdata, r_err); end
        n_checks++; if ({bus_req[0], ioreq[0], wr[0], d_oe[0], cmd_ready[0]} !== 5'b00001)
            begin n_errors++; $display("FAIL out_end_ctrl got %b exp 00001", {bus_req[0], ioreq[0], wr[0], d_oe[0], cmd_ready[0]}); end
        @(negedge clk28);
        n_checks++; if (rsp_valid[0] !== 1'b0) begin n_errors++; $display("FAIL out_rsp_pulse got %b exp 0", rsp_valid[0]); end
        n_checks++; if ({a_out[0], rsp_rdata[0]} !== {16'h7FFD, 8'hFF}) begin n_errors++; $display("FAIL out_hold got %h exp 7FFDFF", {a_out[0], rsp_rdata[0]}); end
    endtask

    task automatic test_in_read();
        run_cmd(0, 1'b0, 16'h00FE, 8'h77, 1'b1, 8'hBF, 0);
        n_checks++; if (r_done !== 1'b1 || r_rdata !== 8'hBF) begin n_errors++; $display("FAIL in_active got done=%b %h exp 1 BF", r_done, r_rdata); end
        n_checks++; if ({r_rd, r_wr, r_oe} !== 3'b100) begin n_errors++; $display("FAIL in_strobes got rd=%b wr=%b oe=%b exp 1 0 0", r_rd, r_wr, r_oe); end
        n_checks++; if (r_a !== 16'h00FE) begin n_errors++; $display("FAIL in_addr got %h exp 00FE", r_a); end
        @(negedge clk28);
        run_cmd(0, 1'b0, 16'h00FE, 8'h00, 1'b0, 8'hBF, 0);
        n_checks++; if (r_done !== 1'b1 || r_rdata !== 8'hFF || r_err !== 1'b0) begin n_errors++; $display("FAIL in_inactive got done=%b %h/%b exp 1 FF/0", r_done, r_rdata, r_err); end
        @(negedge clk28);
    endtask

    task automatic test_grant_timeout();
        run_cmd(0, 1'b1, 16'h1FFD, 8'h04, 1'b0, 8'h00, 1);
        n_checks++; if (r_done !== 1'b1) begin n_errors++; $display("FAIL tmo_done got %b exp 1", r_done); end
        n_checks++; if (r_strb_req != 4) begin n_errors++; $display("FAIL tmo_busreq_strobes got %0d exp 4", r_strb_req); end
        n_checks++; if ({r_err, r_rdata} !== {1'b1, 8'hFF}) begin n_errors++; $display("FAIL tmo_rsp got %b/%h exp 1/FF", r_err, r_rdata); end
        n_checks++; if ({r_io, r_rd, r_wr} !== 3'b000) begin n_errors++; $display("FAIL tmo_no_cycle got %b exp 000", {r_io, r_rd, r_wr}); end
        n_checks++; if ({bus_req[0], cmd_ready[0]} !== 2'b01) begin n_errors++; $display("FAIL tmo_end got %b exp 01", {bus_req[0], cmd_ready[0]}); end
        @(negedge clk28);
    endtask

    task automatic test_late_grant();
        run_cmd(0, 1'b0, 16'hDFFD, 8'h00, 1'b1, 8'h3C, 2);
        n_checks++; if (r_done !== 1'b1 || r_strb != 7) begin n_errors++; $display("FAIL late_latency got done=%b %0d exp 1 7", r_done, r_strb); end
        n_checks++; if ({r_err, r_rdata} !== {1'b0, 8'h3C}) begin n_errors++; $display("FAIL late_rsp got %b/%h exp 0/3C", r_err, r_rdata); end
        n_checks++; if (r_strb_io != 3) begin n_errors++; $display("FAIL late_ioreq_strobes got %0d exp 3", r_strb_io); end
        @(negedge clk28);
    endtask

    task automatic test_zero_wait();
        run_cmd(1, 1'b1, 16'h00FE, 8'h07, 1'b0, 8'h00, 0);
        n_checks++; if (r_done !== 1'b1 || r_strb != 4) begin n_errors++; $display("FAIL ws0_latency got done=%b %0d exp 1 4", r_done, r_strb); end
        n_checks++; if (r_strb_io != 2) begin n_errors++; $display("FAIL ws0_ioreq_strobes got %0d exp 2", r_strb_io); end
        n_checks++; if ({r_a, r_d, r_oe} !== {16'h00FE, 8'h07, 1'b1}) begin n_errors++; $display("FAIL ws0_bus got %h %h %b exp 00FE 07 1", r_a, r_d, r_oe); end
        @(negedge clk28);
    endtask

    task automatic test_back_to_back();
        run_cmd(0, 1'b1, 16'h7FFD, 8'h10, 1'b0, 8'h00, 0);
        n_checks++; if ({r_done, cmd_ready[0], bus_req[0]} !== 3'b110) begin n_errors++; $display("FAIL b2b_gap got done,ready,req=%b exp 110", {r_done, cmd_ready[0], bus_req[0]}); end
        run_cmd(0, 1'b0, 16'h001F, 8'h00, 1'b1, 8'h1A, 0);
        n_checks++; if (r_ready0 !== 1'b1) begin n_errors++; $display("FAIL b2b_ready got %b exp 1", r_ready0); end
        n_checks++; if (r_done !== 1'b1 || r_strb != 5 || r_rdata !== 8'h1A) begin n_errors++; $display("FAIL b2b_second got done=%b %0d %h exp 1 5 1A", r_done, r_strb, r_rdata); end
        @(negedge clk28);
    endtask

    task automatic test_reset_mid();
        int seen;
        logic hit;
        seen = 0;
        hit = 0;
        cmd_we = 1'b1; cmd_addr = 16'h7FFD; cmd_wdata = 8'h30; bus_grant = 1'b1;
        cmd_valid[0] = 1'b1;
        @(negedge clk28);
        cmd_valid[0] = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (ioreq[0]) hit = 1;
            else @(negedge clk28);
        end
        n_checks++; if (hit !== 1'b1) begin n_errors++; $display("FAIL rstmid_reach_t2 got %b exp 1", hit); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({ioreq[0], wr[0], d_oe[0], bus_req[0], cmd_ready[0]} !== 5'b00001)
            begin n_errors++; $display("FAIL rstmid_async got %b exp 00001", {ioreq[0], wr[0], d_oe[0], bus_req[0], cmd_ready[0]}); end
        @(negedge clk28);
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (rsp_valid[0]) seen++;
            @(negedge clk28);
        end
        n_checks++; if (seen != 0) begin n_errors++; $display("FAIL rstmid_no_rsp got %0d pulses exp 0", seen); end
        n_checks++; if ({cmd_ready[0], bus_req[0]} !== 2'b10) begin n_errors++; $display("FAIL rstmid_idle got %b exp 10", {cmd_ready[0], bus_req[0]}); end
    endtask

    initial begin
        cmd_valid[0] = 1'b0;
        cmd_valid[1] = 1'b0;
        test_reset();
        test_out_write();
        test_in_read();
        test_grant_timeout();
        test_late_grant();
        test_zero_wait();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_io_initiator.md
Name: cpu_io_initiator

Overview:
- On-chip initiator of Z80-style I/O cycles toward the port decoder. It is the requesting end of the same bus that the port responder answers.
- Accepts single commands: address, write flag and write data. It requests the bus, runs a T1/T2/TW/T3 I/O cycle paced by clkcpu_ck, samples the responder's read data, and returns a one-shot response.
- Used by the magic/service controller to program #7FFD/#1FFD/#DFFD/#FE and to read #FE/#FF/Kempston without the CPU.

Parameters:
- WAIT_STATES, 1, number of TW states inserted between T2 and T3 (0..7).
- GRANT_TIMEOUT, 255, clkcpu_ck strobes spent waiting for bus_grant before the command aborts (1..255).

Ports:
- clk28  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clkcpu_ck  in  1  one-clk28-wide strobe per CPU clock; every state transition after IDLE happens only on this strobe
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_we  in  1  1 = OUT, 0 = IN
- cmd_addr  in  16  port address
- cmd_wdata  in  8  OUT data
- rsp_valid  out  1  one-clk28 pulse at command completion
- rsp_rdata  out  8  IN data, or 8'hFF on write or abort
- rsp_err  out  1  set with rsp_valid when the command aborted on grant timeout
- bus_req  out  1  request bus from the CPU
- bus_grant  in  1  CPU has released the bus
- a_out  out  16  address to bus
- d_out  out  8  write data to bus
- d_oe  out  1  d_out drive enable
- ioreq  out  1  I/O request
- rd  out  1  read strobe
- wr  out  1  write strobe
- d_in  in  8  responder read data
- d_in_active  in  1  responder is driving d_in

Behaviour:
- Reset: all outputs are 0 except cmd_ready=1 and rsp_rdata=8'hFF. State is IDLE. Reset takes effect asynchronously at any point, including mid-cycle; no response is issued for the aborted command.
- All outputs are registered.
- States: IDLE, REQ, T1, T2, TW, T3.
- IDLE:
  - A command is accepted on clk28 when cmd_valid && cmd_ready, independent of clkcpu_ck.
  - On accept: latch cmd_we, cmd_addr and cmd_wdata; set bus_req=1; clear the timeout counter; go to REQ. cmd_ready drops on the next edge.
- REQ:
  - On a clkcpu_ck strobe with bus_grant=1, go to T1.
  - On a clkcpu_ck strobe with bus_grant=0, increment the timeout counter. The strobe that brings the count to GRANT_TIMEOUT aborts instead: rsp_valid=1, rsp_err=1, rsp_rdata=FF, bus_req=0, go to IDLE.
- T1 (entered on a strobe): a_out=latched address; d_out=latched data; d_oe=we. ioreq, rd and wr stay 0.
- T2 (next strobe): ioreq=1, rd=~we, wr=we.
  - The next strobe goes to TW if WAIT_STATES>0, otherwise to T3.
- TW: strobes stay asserted. A wait counter runs; after WAIT_STATES strobes, go to T3.
- T3: strobes stay asserted. On the closing strobe edge, all of the following happen in one clk28 edge:
  - rsp_rdata = we ? FF : (d_in_active ? d_in : FF)
  - rsp_valid=1, rsp_err=0
  - ioreq, rd, wr, d_oe and bus_req go to 0
  - state returns to IDLE
- rsp_valid is high for exactly one clk28 cycle. rsp_rdata and rsp_err hold their values until the next response.
- a_out retains its last value after the cycle; d_oe=0 outside T1..T3.
- If bus_grant drops after T1 is entered, the cycle still runs to completion (grant is a hold contract). bus_grant is sampled only in REQ.
- Latency with grant already high: accept, then REQ/T1/T2/(WAIT_STATES×TW)/T3 = 4+WAIT_STATES strobes. The response appears on the final strobe edge.
- Back-to-back commands: a new command can be accepted in the clk28 cycle after rsp_valid, when the block is back in IDLE. bus_req deasserts for at least that one cycle.
- cmd_* inputs are ignored outside IDLE.

Test Plan:
- OUT #7FFD=0x15, grant tied high, WAIT_STATES=1, clkcpu_ck every 8 clk28 -> wr and ioreq high for exactly 3 strobe periods (T2, TW, T3) with a_out=7FFD, d_out=15, d_oe=1; rsp_valid after strobe 5; rsp_rdata=FF; rsp_err=0; rd stays 0 throughout.
- IN #00FE with d_in_active=1, d_in=0xBF during T3 -> rd=1, rsp_rdata=BF. Repeat with d_in_active=0 -> rsp_rdata=FF.
- GRANT_TIMEOUT=4, grant held low -> bus_req high for 4 strobes, then rsp_valid with rsp_err=1 and rsp_rdata=FF; ioreq, rd and wr never asserted.
- Grant asserted after 2 strobes; grant dropped during TW -> cycle completes normally; rsp_err=0.
- WAIT_STATES=0 -> exactly 2 strobes with ioreq=1. Two back-to-back commands -> second cmd_ready in the cycle after the first rsp_valid; bus_req low for at least 1 cycle between commands.
- rst_n pulsed low during T2 of a write -> ioreq, wr, d_oe and bus_req go to 0 immediately; cmd_ready=1; no rsp_valid.
